// File: rtl/cbm_state_updater_pkg.sv
// Shared definitions for the CBM hidden-neuron state stage.
//   state_t     : FSM encodings (INIT/EMIT/WAIT/CALC, 2 bits).
//   idx_width   : neuron index counter width, max(1, $clog2(NH)).
//   step_width  : signed step arithmetic width, AW+2.
package cbm_state_updater_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_EMIT = 2'd1,
        ST_WAIT = 2'd2,
        ST_CALC = 2'd3
    } state_t;

    function automatic int idx_width(input int nh);
        return (nh > 1) ? $clog2(nh) : 1;
    endfunction

    function automatic int step_width(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/cbm_state_updater_phase_step.sv
// Combinational phase update for one chaotic Boltzmann machine neuron.
//   iU : signed summed accumulator for the neuron (AW bits)
//   iS : current binary state
//   iX : current phase (PW bits, unsigned)
//   oX : next phase
//   oS : next binary state
// The drive is u when s=1 and -u when s=0, so a positive input shortens
// the rise toward s=1 and stretches the fall back to s=0.
module cbm_state_updater_phase_step
    import cbm_state_updater_pkg::*;
#(
    parameter int AW      = 10,
    parameter int PW      = 8,
    parameter int BASE    = 16,
    parameter int SH      = 4,
    parameter int MAXSTEP = 64
) (
    input  logic signed [AW-1:0] iU,
    input  logic                 iS,
    input  logic [PW-1:0]        iX,
    output logic [PW-1:0]        oX,
    output logic                 oS
);

    localparam int SW = step_width(AW);

    localparam logic signed [AW-1:0] U_MIN  = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] U_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] BASE_S = SW'(BASE);
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAXSTEP);
    localparam logic signed [SW-1:0] ONE_S  = SW'(1);
    localparam logic [PW:0]          X_TOP  = {1'b0, {PW{1'b1}}};

    logic signed [AW-1:0] w_e;
    logic signed [SW-1:0] w_e_ext;
    logic signed [SW-1:0] w_raw;
    logic [PW-1:0]        w_step;
    logic [PW:0]          w_sum;

    always_comb begin
        // Negating the most-negative code would wrap back to itself, so it
        // saturates to the most-positive code instead.
        w_e = iU;
        if (!iS) begin
            w_e = (iU == U_MIN) ? U_MAX : -iU;
        end

        // Two guard bits keep BASE - (e >>> SH) from overflowing.
        w_e_ext = {{2{w_e[AW-1]}}, w_e};
        w_raw   = BASE_S - (w_e_ext >>> SH);

        // The step is never 0, so every neuron keeps oscillating.
        if (w_raw < ONE_S) begin
            w_step = PW'(1);
        end else if (w_raw > MAX_S) begin
            w_step = PW'(MAXSTEP);
        end else begin
            w_step = w_raw[PW-1:0];
        end

        w_sum = {1'b0, iX} + {1'b0, w_step};

        oX = iX;
        oS = iS;
        if (!iS) begin
            if (w_sum >= X_TOP) begin
                oX = '1;
                oS = 1'b1;
            end else begin
                oX = w_sum[PW-1:0];
            end
        end else begin
            if (iX <= w_step) begin
                oX = '0;
                oS = 1'b0;
            end else begin
                oX = iX - w_step;
            end
        end
    end

endmodule

// File: rtl/cbm_state_updater.sv
// CBM hidden-neuron state stage. Accepts the per-neuron accumulator vector,
// advances each neuron's phase by one time step (one neuron per cycle through
// a single shared phase-step unit) and emits the NH-bit binary state vector.
//   iCLK, iRST            : clock, asynchronous active-low reset
//   iValid_AS_CbmAccum    : accumulator vector valid
//   oReady_AS_CbmAccum    : ready for an accumulator vector (WAIT state)
//   iData_AS_CbmAccum     : neuron i at [i*AW +: AW], signed
//   oValid_BM_CbmState    : state vector valid (EMIT state)
//   iReady_BM_CbmState    : downstream accepts the state vector
//   oData_BM_CbmState     : binary state s[i]; stable only while valid
//   oDbg_State            : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid/ready are decoded from the registered state only, never from
// the partner's signal, and a raised valid is held until the transfer.
module cbm_state_updater
    import cbm_state_updater_pkg::*;
#(
    parameter int NH      = 16,
    parameter int AW      = 10,
    parameter int PW      = 8,
    parameter int BASE    = 16,
    parameter int SH      = 4,
    parameter int MAXSTEP = 64
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iValid_AS_CbmAccum,
    output logic               oReady_AS_CbmAccum,
    input  logic [NH*AW-1:0]   iData_AS_CbmAccum,
    output logic               oValid_BM_CbmState,
    input  logic               iReady_BM_CbmState,
    output logic [NH-1:0]      oData_BM_CbmState,
    output state_t             oDbg_State
);

    localparam int NW = idx_width(NH);

    state_t              r_state;
    state_t              w_state_next;
    logic [NW-1:0]       r_n;
    logic [NH*AW-1:0]    r_hold;
    logic [NH-1:0]       r_s;
    logic [PW-1:0]       r_x [NH];

    logic                w_capture;
    logic                w_update;
    logic                w_last;
    logic signed [AW-1:0] w_u;
    logic [PW-1:0]       w_x_next;
    logic                w_s_next;

    assign w_last = (r_n == NW'(NH - 1));
    assign w_u    = $signed(r_hold[int'(r_n)*AW +: AW]);

    cbm_state_updater_phase_step #(
        .AW      (AW),
        .PW      (PW),
        .BASE    (BASE),
        .SH      (SH),
        .MAXSTEP (MAXSTEP)
    ) u_phase_step (
        .iU (w_u),
        .iS (r_s[r_n]),
        .iX (r_x[r_n]),
        .oX (w_x_next),
        .oS (w_s_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            ST_INIT: w_state_next = ST_EMIT;
            ST_EMIT: begin
                if (iReady_BM_CbmState) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (iValid_AS_CbmAccum) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_update = 1'b1;
                if (w_last) w_state_next = ST_EMIT;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= ST_INIT;
            r_n     <= '0;
            r_hold  <= '0;
            r_s     <= '0;
            for (int i = 0; i < NH; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_hold <= iData_AS_CbmAccum;
                r_n    <= '0;
            end
            if (w_update) begin
                r_s[r_n] <= w_s_next;
                r_x[r_n] <= w_x_next;
                if (!w_last) r_n <= r_n + NW'(1);
            end
        end
    end

    assign oValid_BM_CbmState = (r_state == ST_EMIT);
    assign oReady_AS_CbmAccum = (r_state == ST_WAIT);
    assign oData_BM_CbmState  = r_s;
    assign oDbg_State         = r_state;

endmodule

// File: tb/tb_cbm_state_updater.sv
module tb_cbm_state_updater;
    import cbm_state_updater_pkg::*;

    localparam int NH = 4;
    localparam int AW = 12;
    localparam int PW = 8;
    localparam int BASE = 16;
    localparam int SH = 4;
    localparam int MAXSTEP = 64;

    logic             iCLK = 1'b0;
    logic             iRST;
    logic             iValid;
    logic             oReady;
    logic [NH*AW-1:0] iData;
    logic             oValid;
    logic             iReady;
    logic [NH-1:0]    oData;
    state_t           oDbg;

    always #5 iCLK = ~iCLK;

    cbm_state_updater #(
        .NH(NH), .AW(AW), .PW(PW), .BASE(BASE), .SH(SH), .MAXSTEP(MAXSTEP)
    ) dut (
        .iCLK               (iCLK),
        .iRST               (iRST),
        .iValid_AS_CbmAccum (iValid),
        .oReady_AS_CbmAccum (oReady),
        .iData_AS_CbmAccum  (iData),
        .oValid_BM_CbmState (oValid),
        .iReady_BM_CbmState (iReady),
        .oData_BM_CbmState  (oData),
        .oDbg_State         (oDbg)
    );

    typedef struct {
        string            name;
        logic [NH*AW-1:0] data;
        int               reps;
        logic [NH-1:0]    exp;
    } vec_t;

    vec_t tbl [11];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [NH*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic wait_valid(input string name);
        int c = 0;
        while (!oValid && c < 100) begin
            tick();
            c++;
        end
        if (!oValid) check({name, " valid timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_ready(input string name);
        int c = 0;
        while (!oReady && c < 100) begin
            tick();
            c++;
        end
        if (!oReady) check({name, " ready timeout"}, 32'd0, 32'd1);
    endtask

    // One full round: take the emitted vector, feed d, wait for the result.
    task automatic do_round(input logic [NH*AW-1:0] d);
        logic [63:0] junk;
        wait_valid("emit");
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        wait_ready("wait");
        iValid = 1'b1;
        iData  = d;
        tick();
        iValid = 1'b0;
        junk   = {$urandom(), $urandom()};
        iData  = junk[NH*AW-1:0];
        wait_valid("calc");
    endtask

    initial begin
        int lat;

        // Hand-computed from phase 0 / state 0 at reset.
        tbl[0]  = '{"zero r1-15",   pk(0, 0, 0, 0),              15, 4'b0000};
        tbl[1]  = '{"zero r16",     pk(0, 0, 0, 0),               1, 4'b1111};
        tbl[2]  = '{"zero r17-31",  pk(0, 0, 0, 0),              15, 4'b1111};
        tbl[3]  = '{"zero r32",     pk(0, 0, 0, 0),               1, 4'b0000};
        tbl[4]  = '{"drive r1-3",   pk(1000, -1000, 0, 0),        3, 4'b0000};
        tbl[5]  = '{"drive r4",     pk(1000, -1000, 0, 0),        1, 4'b0001};
        tbl[6]  = '{"drive r5-15",  pk(1000, -1000, 0, 0),       11, 4'b0001};
        tbl[7]  = '{"drive r16",    pk(1000, -1000, 0, 0),        1, 4'b1101};
        tbl[8]  = '{"sat r1-3",     pk(-2048, -2048, 0, 0),       3, 4'b1101};
        tbl[9]  = '{"sat r4",       pk(-2048, -2048, 0, 0),       1, 4'b1100};
        tbl[10] = '{"sat r5",       pk(-2048, -2048, 0, 0),       1, 4'b1100};

        iRST   = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iData  = '0;

        // Reset and prime.
        repeat (3) @(posedge iCLK);
        #1;
        check("rst valid", 32'(oValid), 32'd0);
        check("rst ready", 32'(oReady), 32'd0);
        check("rst data",  32'(oData),  32'd0);
        check("rst state", 32'(oDbg),   32'(ST_INIT));
        @(negedge iCLK);
        iRST = 1'b1;
        #1;
        check("prime c1 valid", 32'(oValid), 32'd0);
        check("prime c1 ready", 32'(oReady), 32'd0);
        tick();
        check("prime c2 valid", 32'(oValid), 32'd1);
        check("prime c2 data",  32'(oData),  32'd0);
        check("prime c2 ready", 32'(oReady), 32'd0);

        // Table-driven rounds.
        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                do_round(tbl[i].data);
            end
            check(tbl[i].name, 32'(oData), 32'(tbl[i].exp));
        end

        // Latency: count edges from the accepting edge to oValid.
        wait_valid("lat emit");
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        wait_ready("lat wait");
        iValid = 1'b1;
        iData  = pk(0, 0, 0, 0);
        tick();
        iValid = 1'b0;
        iData  = pk(2047, 2047, 2047, 2047);
        check("lat calc no valid", 32'(oValid), 32'd0);
        lat = 0;
        while (!oValid && lat < 50) begin
            tick();
            lat++;
        end
        check("lat edges", 32'(lat), 32'd4);
        check("lat data", 32'(oData), 32'b1100);

        // Backpressure: hold iReady low for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp valid", 32'(oValid), 32'd1);
            check("bp ready", 32'(oReady), 32'd0);
            check("bp data",  32'(oData),  32'b1100);
        end
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("bp wait ready", 32'(oReady), 32'd1);
        check("bp wait valid", 32'(oValid), 32'd0);

        // Mid-operation reset at neuron index 2.
        iValid = 1'b1;
        iData  = pk(2047, 2047, 2047, 2047);
        tick();
        iValid = 1'b0;
        tick();
        tick();
        check("mid state calc", 32'(oDbg), 32'(ST_CALC));
        iRST = 1'b0;
        #1;
        check("mid rst valid", 32'(oValid), 32'd0);
        check("mid rst ready", 32'(oReady), 32'd0);
        check("mid rst data",  32'(oData),  32'd0);
        check("mid rst state", 32'(oDbg),   32'(ST_INIT));
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        tick();
        check("post rst valid", 32'(oValid), 32'd1);
        check("post rst data",  32'(oData),  32'd0);
        for (int r = 0; r < 15; r++) do_round(pk(0, 0, 0, 0));
        check("post rst r15", 32'(oData), 32'b0000);
        do_round(pk(0, 0, 0, 0));
        check("post rst r16", 32'(oData), 32'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
